// File: rtl/butterfly_pkg.sv
// Shared widths, complex sample type and the overflow helper for the butterfly stage.
// Build option: define BUTTERFLY_SATURATE_EN to clamp instead of wrapping on overflow.
package butterfly_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TW_FRAC = 15;
  localparam int unsigned NUM_BF  = 8;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Reduce a wide signed value to DATA_W bits: clamp when saturation is built in, else wrap.
  function automatic logic signed [DATA_W-1:0] fit16(input logic signed [32:0] v);
`ifdef BUTTERFLY_SATURATE_EN
    if (v > 33'sd32767) begin
      return 16'sh7fff;
    end else if (v < -33'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[DATA_W-1:0];
    end
`else
    return v[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/butterfly_block_if.sv
// Flat sample/twiddle/result bus of the eight-lane butterfly stage.
// master drives operands; slave (the butterfly block) drives results.
interface butterfly_block_if;
  import butterfly_pkg::*;

  logic in_valid;
  logic out_valid;

  logic [DATA_W-1:0] input_1_real,  input_1_imaginary,  input_2_real,  input_2_imaginary;
  logic [DATA_W-1:0] input_3_real,  input_3_imaginary,  input_4_real,  input_4_imaginary;
  logic [DATA_W-1:0] input_5_real,  input_5_imaginary,  input_6_real,  input_6_imaginary;
  logic [DATA_W-1:0] input_7_real,  input_7_imaginary,  input_8_real,  input_8_imaginary;
  logic [DATA_W-1:0] input_9_real,  input_9_imaginary,  input_10_real, input_10_imaginary;
  logic [DATA_W-1:0] input_11_real, input_11_imaginary, input_12_real, input_12_imaginary;
  logic [DATA_W-1:0] input_13_real, input_13_imaginary, input_14_real, input_14_imaginary;
  logic [DATA_W-1:0] input_15_real, input_15_imaginary, input_16_real, input_16_imaginary;

  logic [DATA_W-1:0] twiddle1_real, twiddle1_imaginary, twiddle2_real, twiddle2_imaginary;
  logic [DATA_W-1:0] twiddle3_real, twiddle3_imaginary, twiddle4_real, twiddle4_imaginary;
  logic [DATA_W-1:0] twiddle5_real, twiddle5_imaginary, twiddle6_real, twiddle6_imaginary;
  logic [DATA_W-1:0] twiddle7_real, twiddle7_imaginary, twiddle8_real, twiddle8_imaginary;

  logic [DATA_W-1:0] output_1_real,  output_1_imaginary,  output_2_real,  output_2_imaginary;
  logic [DATA_W-1:0] output_3_real,  output_3_imaginary,  output_4_real,  output_4_imaginary;
  logic [DATA_W-1:0] output_5_real,  output_5_imaginary,  output_6_real,  output_6_imaginary;
  logic [DATA_W-1:0] output_7_real,  output_7_imaginary,  output_8_real,  output_8_imaginary;
  logic [DATA_W-1:0] output_9_real,  output_9_imaginary,  output_10_real, output_10_imaginary;
  logic [DATA_W-1:0] output_11_real, output_11_imaginary, output_12_real, output_12_imaginary;
  logic [DATA_W-1:0] output_13_real, output_13_imaginary, output_14_real, output_14_imaginary;
  logic [DATA_W-1:0] output_15_real, output_15_imaginary, output_16_real, output_16_imaginary;

  modport master (
    output in_valid,
    output input_1_real,  input_1_imaginary,  input_2_real,  input_2_imaginary,
           input_3_real,  input_3_imaginary,  input_4_real,  input_4_imaginary,
           input_5_real,  input_5_imaginary,  input_6_real,  input_6_imaginary,
           input_7_real,  input_7_imaginary,  input_8_real,  input_8_imaginary,
           input_9_real,  input_9_imaginary,  input_10_real, input_10_imaginary,
           input_11_real, input_11_imaginary, input_12_real, input_12_imaginary,
           input_13_real, input_13_imaginary, input_14_real, input_14_imaginary,
           input_15_real, input_15_imaginary, input_16_real, input_16_imaginary,
    output twiddle1_real, twiddle1_imaginary, twiddle2_real, twiddle2_imaginary,
           twiddle3_real, twiddle3_imaginary, twiddle4_real, twiddle4_imaginary,
           twiddle5_real, twiddle5_imaginary, twiddle6_real, twiddle6_imaginary,
           twiddle7_real, twiddle7_imaginary, twiddle8_real, twiddle8_imaginary,
    input  out_valid,
    input  output_1_real,  output_1_imaginary,  output_2_real,  output_2_imaginary,
           output_3_real,  output_3_imaginary,  output_4_real,  output_4_imaginary,
           output_5_real,  output_5_imaginary,  output_6_real,  output_6_imaginary,
           output_7_real,  output_7_imaginary,  output_8_real,  output_8_imaginary,
           output_9_real,  output_9_imaginary,  output_10_real, output_10_imaginary,
           output_11_real, output_11_imaginary, output_12_real, output_12_imaginary,
           output_13_real, output_13_imaginary, output_14_real, output_14_imaginary,
           output_15_real, output_15_imaginary, output_16_real, output_16_imaginary
  );

  modport slave (
    input  in_valid,
    input  input_1_real,  input_1_imaginary,  input_2_real,  input_2_imaginary,
           input_3_real,  input_3_imaginary,  input_4_real,  input_4_imaginary,
           input_5_real,  input_5_imaginary,  input_6_real,  input_6_imaginary,
           input_7_real,  input_7_imaginary,  input_8_real,  input_8_imaginary,
           input_9_real,  input_9_imaginary,  input_10_real, input_10_imaginary,
           input_11_real, input_11_imaginary, input_12_real, input_12_imaginary,
           input_13_real, input_13_imaginary, input_14_real, input_14_imaginary,
           input_15_real, input_15_imaginary, input_16_real, input_16_imaginary,
    input  twiddle1_real, twiddle1_imaginary, twiddle2_real, twiddle2_imaginary,
           twiddle3_real, twiddle3_imaginary, twiddle4_real, twiddle4_imaginary,
           twiddle5_real, twiddle5_imaginary, twiddle6_real, twiddle6_imaginary,
           twiddle7_real, twiddle7_imaginary, twiddle8_real, twiddle8_imaginary,
    output out_valid,
    output output_1_real,  output_1_imaginary,  output_2_real,  output_2_imaginary,
           output_3_real,  output_3_imaginary,  output_4_real,  output_4_imaginary,
           output_5_real,  output_5_imaginary,  output_6_real,  output_6_imaginary,
           output_7_real,  output_7_imaginary,  output_8_real,  output_8_imaginary,
           output_9_real,  output_9_imaginary,  output_10_real, output_10_imaginary,
           output_11_real, output_11_imaginary, output_12_real, output_12_imaginary,
           output_13_real, output_13_imaginary, output_14_real, output_14_imaginary,
           output_15_real, output_15_imaginary, output_16_real, output_16_imaginary
  );

endinterface

// File: rtl/butterfly_lane.sv
// One combinational radix-2 DIT butterfly: O1 = A + B*W, O2 = A - B*W (Q1.15 twiddle).
// Overflow handling follows butterfly_pkg::fit16 (BUTTERFLY_SATURATE_EN selects clamping).
module butterfly_lane
  import butterfly_pkg::*;
(
  input  cplx_t i_a,
  input  cplx_t i_b,
  input  cplx_t i_w,
  output cplx_t o_o1,
  output cplx_t o_o2
);

  logic signed [31:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [32:0] w_re_sum, w_im_sum, w_re_sh, w_im_sh;
  logic signed [16:0] w_s1_re, w_s1_im, w_s2_re, w_s2_im;
  cplx_t              w_p;

  always_comb begin
    w_rr = i_b.re * i_w.re;
    w_ii = i_b.im * i_w.im;
    w_ri = i_b.re * i_w.im;
    w_ir = i_b.im * i_w.re;

    w_re_sum = {w_rr[31], w_rr} - {w_ii[31], w_ii};
    w_im_sum = {w_ri[31], w_ri} + {w_ir[31], w_ir};
    // Arithmetic shift floors toward -inf; no rounding term.
    w_re_sh  = w_re_sum >>> TW_FRAC;
    w_im_sh  = w_im_sum >>> TW_FRAC;

    w_p.re = fit16(w_re_sh);
    w_p.im = fit16(w_im_sh);

    w_s1_re = {i_a.re[DATA_W-1], i_a.re} + {w_p.re[DATA_W-1], w_p.re};
    w_s1_im = {i_a.im[DATA_W-1], i_a.im} + {w_p.im[DATA_W-1], w_p.im};
    w_s2_re = {i_a.re[DATA_W-1], i_a.re} - {w_p.re[DATA_W-1], w_p.re};
    w_s2_im = {i_a.im[DATA_W-1], i_a.im} - {w_p.im[DATA_W-1], w_p.im};

    o_o1.re = fit16({{16{w_s1_re[16]}}, w_s1_re});
    o_o1.im = fit16({{16{w_s1_im[16]}}, w_s1_im});
    o_o2.re = fit16({{16{w_s2_re[16]}}, w_s2_re});
    o_o2.im = fit16({{16{w_s2_im[16]}}, w_s2_im});
  end

endmodule

// File: rtl/butterfly_block.sv
// Eight parallel butterflies with registered results and one shared valid flag (1-cycle latency).
// Build option: BUTTERFLY_SATURATE_EN (see butterfly_pkg) switches wrap to saturation.
module butterfly_block
  import butterfly_pkg::*;
(
  input logic              clk,
  input logic              reset,
  butterfly_block_if.slave bus
);

  cplx_t w_a  [NUM_BF];
  cplx_t w_b  [NUM_BF];
  cplx_t w_w  [NUM_BF];
  cplx_t w_o1 [NUM_BF];
  cplx_t w_o2 [NUM_BF];
  cplx_t r_o1 [NUM_BF];
  cplx_t r_o2 [NUM_BF];
  logic  r_valid;

  assign w_a[0] = {bus.input_1_real,  bus.input_1_imaginary};
  assign w_b[0] = {bus.input_2_real,  bus.input_2_imaginary};
  assign w_a[1] = {bus.input_3_real,  bus.input_3_imaginary};
  assign w_b[1] = {bus.input_4_real,  bus.input_4_imaginary};
  assign w_a[2] = {bus.input_5_real,  bus.input_5_imaginary};
  assign w_b[2] = {bus.input_6_real,  bus.input_6_imaginary};
  assign w_a[3] = {bus.input_7_real,  bus.input_7_imaginary};
  assign w_b[3] = {bus.input_8_real,  bus.input_8_imaginary};
  assign w_a[4] = {bus.input_9_real,  bus.input_9_imaginary};
  assign w_b[4] = {bus.input_10_real, bus.input_10_imaginary};
  assign w_a[5] = {bus.input_11_real, bus.input_11_imaginary};
  assign w_b[5] = {bus.input_12_real, bus.input_12_imaginary};
  assign w_a[6] = {bus.input_13_real, bus.input_13_imaginary};
  assign w_b[6] = {bus.input_14_real, bus.input_14_imaginary};
  assign w_a[7] = {bus.input_15_real, bus.input_15_imaginary};
  assign w_b[7] = {bus.input_16_real, bus.input_16_imaginary};

  assign w_w[0] = {bus.twiddle1_real, bus.twiddle1_imaginary};
  assign w_w[1] = {bus.twiddle2_real, bus.twiddle2_imaginary};
  assign w_w[2] = {bus.twiddle3_real, bus.twiddle3_imaginary};
  assign w_w[3] = {bus.twiddle4_real, bus.twiddle4_imaginary};
  assign w_w[4] = {bus.twiddle5_real, bus.twiddle5_imaginary};
  assign w_w[5] = {bus.twiddle6_real, bus.twiddle6_imaginary};
  assign w_w[6] = {bus.twiddle7_real, bus.twiddle7_imaginary};
  assign w_w[7] = {bus.twiddle8_real, bus.twiddle8_imaginary};

  for (genvar k = 0; k < NUM_BF; k++) begin : g_lane
    butterfly_lane u_lane (
      .i_a  (w_a[k]),
      .i_b  (w_b[k]),
      .i_w  (w_w[k]),
      .o_o1 (w_o1[k]),
      .o_o2 (w_o2[k])
    );
  end

  // Reset wins over in_valid; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_o1    <= '{default: '0};
      r_o2    <= '{default: '0};
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_o1 <= w_o1;
        r_o2 <= w_o2;
      end
    end
  end

  assign bus.out_valid = r_valid;

  assign {bus.output_1_real,  bus.output_1_imaginary}  = r_o1[0];
  assign {bus.output_2_real,  bus.output_2_imaginary}  = r_o2[0];
  assign {bus.output_3_real,  bus.output_3_imaginary}  = r_o1[1];
  assign {bus.output_4_real,  bus.output_4_imaginary}  = r_o2[1];
  assign {bus.output_5_real,  bus.output_5_imaginary}  = r_o1[2];
  assign {bus.output_6_real,  bus.output_6_imaginary}  = r_o2[2];
  assign {bus.output_7_real,  bus.output_7_imaginary}  = r_o1[3];
  assign {bus.output_8_real,  bus.output_8_imaginary}  = r_o2[3];
  assign {bus.output_9_real,  bus.output_9_imaginary}  = r_o1[4];
  assign {bus.output_10_real, bus.output_10_imaginary} = r_o2[4];
  assign {bus.output_11_real, bus.output_11_imaginary} = r_o1[5];
  assign {bus.output_12_real, bus.output_12_imaginary} = r_o2[5];
  assign {bus.output_13_real, bus.output_13_imaginary} = r_o1[6];
  assign {bus.output_14_real, bus.output_14_imaginary} = r_o2[6];
  assign {bus.output_15_real, bus.output_15_imaginary} = r_o1[7];
  assign {bus.output_16_real, bus.output_16_imaginary} = r_o2[7];

endmodule

// File: tb/tb_butterfly_block.sv
// Scoreboard bench for butterfly_block: integer reference model feeds an expectation queue,
// a negedge monitor pops and compares. Honours BUTTERFLY_SATURATE_EN like the design.
module tb_butterfly_block;

  typedef struct packed {
    logic [15:0][15:0] re;
    logic [15:0][15:0] im;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic rst_seen = 1'b1;

  logic [15:0] in_re [16];
  logic [15:0] in_im [16];
  logic [15:0] tw_re [8];
  logic [15:0] tw_im [8];
  logic [15:0] out_re [16];
  logic [15:0] out_im [16];

  res_t exp_q[$];
  res_t held = '0;
  int   n_chk = 0;
  int   n_err = 0;

  butterfly_block_if bus();

  butterfly_block dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_seen <= reset;

  assign bus.in_valid = in_valid;
  assign bus.input_1_real  = in_re[0];  assign bus.input_1_imaginary  = in_im[0];
  assign bus.input_2_real  = in_re[1];  assign bus.input_2_imaginary  = in_im[1];
  assign bus.input_3_real  = in_re[2];  assign bus.input_3_imaginary  = in_im[2];
  assign bus.input_4_real  = in_re[3];  assign bus.input_4_imaginary  = in_im[3];
  assign bus.input_5_real  = in_re[4];  assign bus.input_5_imaginary  = in_im[4];
  assign bus.input_6_real  = in_re[5];  assign bus.input_6_imaginary  = in_im[5];
  assign bus.input_7_real  = in_re[6];  assign bus.input_7_imaginary  = in_im[6];
  assign bus.input_8_real  = in_re[7];  assign bus.input_8_imaginary  = in_im[7];
  assign bus.input_9_real  = in_re[8];  assign bus.input_9_imaginary  = in_im[8];
  assign bus.input_10_real = in_re[9];  assign bus.input_10_imaginary = in_im[9];
  assign bus.input_11_real = in_re[10]; assign bus.input_11_imaginary = in_im[10];
  assign bus.input_12_real = in_re[11]; assign bus.input_12_imaginary = in_im[11];
  assign bus.input_13_real = in_re[12]; assign bus.input_13_imaginary = in_im[12];
  assign bus.input_14_real = in_re[13]; assign bus.input_14_imaginary = in_im[13];
  assign bus.input_15_real = in_re[14]; assign bus.input_15_imaginary = in_im[14];
  assign bus.input_16_real = in_re[15]; assign bus.input_16_imaginary = in_im[15];
  assign bus.twiddle1_real = tw_re[0];  assign bus.twiddle1_imaginary = tw_im[0];
  assign bus.twiddle2_real = tw_re[1];  assign bus.twiddle2_imaginary = tw_im[1];
  assign bus.twiddle3_real = tw_re[2];  assign bus.twiddle3_imaginary = tw_im[2];
  assign bus.twiddle4_real = tw_re[3];  assign bus.twiddle4_imaginary = tw_im[3];
  assign bus.twiddle5_real = tw_re[4];  assign bus.twiddle5_imaginary = tw_im[4];
  assign bus.twiddle6_real = tw_re[5];  assign bus.twiddle6_imaginary = tw_im[5];
  assign bus.twiddle7_real = tw_re[6];  assign bus.twiddle7_imaginary = tw_im[6];
  assign bus.twiddle8_real = tw_re[7];  assign bus.twiddle8_imaginary = tw_im[7];

  assign out_re[0]  = bus.output_1_real;  assign out_im[0]  = bus.output_1_imaginary;
  assign out_re[1]  = bus.output_2_real;  assign out_im[1]  = bus.output_2_imaginary;
  assign out_re[2]  = bus.output_3_real;  assign out_im[2]  = bus.output_3_imaginary;
  assign out_re[3]  = bus.output_4_real;  assign out_im[3]  = bus.output_4_imaginary;
  assign out_re[4]  = bus.output_5_real;  assign out_im[4]  = bus.output_5_imaginary;
  assign out_re[5]  = bus.output_6_real;  assign out_im[5]  = bus.output_6_imaginary;
  assign out_re[6]  = bus.output_7_real;  assign out_im[6]  = bus.output_7_imaginary;
  assign out_re[7]  = bus.output_8_real;  assign out_im[7]  = bus.output_8_imaginary;
  assign out_re[8]  = bus.output_9_real;  assign out_im[8]  = bus.output_9_imaginary;
  assign out_re[9]  = bus.output_10_real; assign out_im[9]  = bus.output_10_imaginary;
  assign out_re[10] = bus.output_11_real; assign out_im[10] = bus.output_11_imaginary;
  assign out_re[11] = bus.output_12_real; assign out_im[11] = bus.output_12_imaginary;
  assign out_re[12] = bus.output_13_real; assign out_im[12] = bus.output_13_imaginary;
  assign out_re[13] = bus.output_14_real; assign out_im[13] = bus.output_14_imaginary;
  assign out_re[14] = bus.output_15_real; assign out_im[14] = bus.output_15_imaginary;
  assign out_re[15] = bus.output_16_real; assign out_im[15] = bus.output_16_imaginary;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference arithmetic on plain integers: wrap keeps the low 16 bits, saturate clamps first.
  function automatic logic [15:0] fit(input longint v);
    longint t;
    t = v;
`ifdef BUTTERFLY_SATURATE_EN
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
`endif
    return t[15:0];
  endfunction

  function automatic longint sx(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  function automatic res_t model();
    res_t   e;
    longint p_re, p_im;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      p_re = sx(fit((sx(in_re[2*k+1]) * sx(tw_re[k]) - sx(in_im[2*k+1]) * sx(tw_im[k])) >>> 15));
      p_im = sx(fit((sx(in_re[2*k+1]) * sx(tw_im[k]) + sx(in_im[2*k+1]) * sx(tw_re[k])) >>> 15));
      e.re[2*k]   = fit(sx(in_re[2*k]) + p_re);
      e.im[2*k]   = fit(sx(in_im[2*k]) + p_im);
      e.re[2*k+1] = fit(sx(in_re[2*k]) - p_re);
      e.im[2*k+1] = fit(sx(in_im[2*k]) - p_im);
    end
    return e;
  endfunction

  // Apply one cycle of stimulus; returns just after the capturing edge.
  task automatic drive(input logic v, input logic rst);
    in_valid = v;
    reset    = rst;
    if (v && !rst) exp_q.push_back(model());
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi,
                          input logic [15:0] wr, input logic [15:0] wi);
    in_re[2*k] = ar;   in_im[2*k] = ai;
    in_re[2*k+1] = br; in_im[2*k+1] = bi;
    tw_re[k] = wr;     tw_im[k] = wi;
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] corner [5];
    corner = '{16'h7fff, 16'h8000, 16'h0000, 16'h0001, 16'hffff};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  task automatic randomize_all();
    for (int k = 0; k < 8; k++) set_lane(k, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
  endtask

  // Monitor: a reset edge clears everything, a valid result pops the queue, otherwise hold.
  always @(negedge clk) begin
    res_t e;
    if (rst_seen) begin
      held = '0;
      chk("valid_after_reset", {31'd0, bus.out_valid}, 32'd0);
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("rst_o%0d.re", i + 1), {16'd0, out_re[i]}, 32'd0);
        chk($sformatf("rst_o%0d.im", i + 1), {16'd0, out_im[i]}, 32'd0);
      end
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        held = e;
        for (int i = 0; i < 16; i++) begin
          chk($sformatf("o%0d.re", i + 1), {16'd0, out_re[i]}, {16'd0, e.re[i]});
          chk($sformatf("o%0d.im", i + 1), {16'd0, out_im[i]}, {16'd0, e.im[i]});
        end
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("hold_o%0d.re", i + 1), {16'd0, out_re[i]}, {16'd0, held.re[i]});
        chk($sformatf("hold_o%0d.im", i + 1), {16'd0, out_im[i]}, {16'd0, held.im[i]});
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) set_lane(k, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_o1.re", {16'd0, out_re[0]}, 32'd0);

    // P rounds down to zero, so both outputs equal A on every lane.
    for (int k = 0; k < 8; k++) set_lane(k, 16'd5, 16'd4, 16'd3, 16'd2, 16'd2, 16'd1);
    drive(1'b1, 1'b0);
    chk("small_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("small_o1.re", {16'd0, out_re[0]}, 32'd5);
    chk("small_o2.im", {16'd0, out_im[1]}, 32'd4);
    chk("small_o16.re", {16'd0, out_re[15]}, 32'd5);

    set_lane(0, 16'd100, 16'd0, 16'd50, 16'd0, 16'h7fff, 16'd0);
    drive(1'b1, 1'b0);
    chk("wmax_o1.re", {16'd0, out_re[0]}, 32'd149);
    chk("wmax_o2.re", {16'd0, out_re[1]}, 32'd51);

    set_lane(0, 16'd100, 16'd0, 16'd50, 16'd0, 16'h8000, 16'd0);
    drive(1'b1, 1'b0);
    chk("wneg_o1.re", {16'd0, out_re[0]}, 32'd50);
    chk("wneg_o2.re", {16'd0, out_re[1]}, 32'd150);

    randomize_all();
    set_lane(1, 16'd0, 16'd0, 16'd50, 16'd0, 16'd0, 16'h7fff);
    drive(1'b1, 1'b0);
    chk("jw_o3.im", {16'd0, out_im[2]}, 32'd49);
    chk("jw_o4.im", {16'd0, out_im[3]}, 32'h0000ffcf);
    chk("jw_o3.re", {16'd0, out_re[2]}, 32'd0);

    set_lane(0, 16'h7fff, 16'd0, 16'h7fff, 16'd0, 16'h7fff, 16'd0);
    drive(1'b1, 1'b0);
`ifdef BUTTERFLY_SATURATE_EN
    chk("ovf_o1.re", {16'd0, out_re[0]}, 32'h00007fff);
`else
    chk("ovf_o1.re", {16'd0, out_re[0]}, 32'h0000fffd);
`endif
    chk("ovf_o2.re", {16'd0, out_re[1]}, 32'd1);

    // Back-to-back sets, idle hold, then reset landing together with in_valid.
    randomize_all();
    drive(1'b1, 1'b0);
    randomize_all();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("hold_valid", {31'd0, bus.out_valid}, 32'd0);
    randomize_all();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    chk("mid_reset_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_reset_o5.im", {16'd0, out_im[4]}, 32'd0);
    drive(1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      randomize_all();
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/butterfly_block.md
Name: butterfly_block

Overview:
- Eight independent radix-2 decimation-in-time FFT butterflies operating in parallel on 16-bit signed complex samples, with one complex twiddle factor per butterfly.
- Sits in one FFT stage between the sample buffer and the next-stage reorder logic.
- Results are registered, one-cycle latency, with a single valid flag covering all eight lanes.

Parameters:
- DATA_W, 16, width of each real/imaginary sample component (two's complement).
- TW_FRAC, 15, fractional bits of twiddle components (Q1.15).
- NUM_BF, 8, number of butterfly lanes; fixed at 8 because the port list is explicit.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input lanes and twiddles valid this cycle.
- input_{2k-1}_real / input_{2k-1}_imaginary  in  16 each  operand A of butterfly k, k=1..8 (inputs 1,3,...,15).
- input_{2k}_real / input_{2k}_imaginary  in  16 each  operand B of butterfly k (inputs 2,4,...,16).
- twiddle{k}_real / twiddle{k}_imaginary  in  16 each  Q1.15 twiddle W of butterfly k, k=1..8.
- output_{2k-1}_real / output_{2k-1}_imaginary  out  16 each  A + B·W for butterfly k.
- output_{2k}_real / output_{2k}_imaginary  out  16 each  A − B·W for butterfly k.
- out_valid  out  1  outputs hold a new result.

Behaviour:
- Reset, clocked only: all 32 output components = 0 and out_valid = 0. Reset has priority over in_valid in the same cycle; data in flight is discarded.
- Lane k computes the complex product P = B·W:
  - P_re = (B_re·W_re − B_im·W_im) >>> TW_FRAC.
  - P_im = (B_re·W_im + B_im·W_re) >>> TW_FRAC.
- Product arithmetic:
  - Products are full 32-bit signed; each sum/difference uses 33 bits.
  - Arithmetic right shift, truncation toward −inf, no rounding.
  - The result is then truncated to 16 bits.
- Output sums: O1 = A + P and O2 = A − P, per component, 17-bit intermediate. The default wraps modulo 2^16 (low 16 bits kept).
- Timing:
  - Edge with in_valid = 1: all outputs load the new results and out_valid = 1 on the following cycle.
  - Edge with in_valid = 0: outputs hold their last values and out_valid = 0.
  - Back-to-back in_valid gives full throughput, one result set per cycle.
- Lanes are fully independent; no cross-lane interaction.
- No backpressure.
- Twiddle 0x8000 represents exactly −1; no twiddle value represents exactly +1 (max 0x7FFF).

Optional Feature:
- Macro BUTTERFLY_SATURATE_EN.
- When defined: each 17-bit A±P result and each shifted product saturates to [−32768, 32767] instead of wrapping.
- When undefined: modulo-2^16 wrap as above.
- Latency is unchanged either way.

Decomposition:
- Package butterfly_pkg holds:
  - DATA_W and TW_FRAC.
  - typedef cplx_t (struct of signed [15:0] re, im).
  - Saturation helper function.
- Sub-module butterfly_lane is purely combinational (A, B, W in; O1, O2 out).
- The top generates 8 butterfly_lane instances, plus the output/valid registers, and maps the flat ports onto cplx_t.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0 and out_valid 0 until the first in_valid.
- All lanes A=5+4j, B=3+2j, W=2+1j, in_valid=1 → next cycle out_valid=1, P=0, O1=O2=5+4j on every lane.
- Lane 1: A=100, B=50, W=0x7FFF → O1=149, O2=51. Same A and B with W=0x8000 → O1=50, O2=150.
- Lane 2: A=0, B=50+0j, W=0+0x7FFFj → O1=0+49j, O2=0−49j. Other lanes loaded with distinct values in the same cycle → no cross-lane corruption.
- Overflow case A=B=W=0x7FFF (imaginary parts 0):
  - Wrap build: O1 = 0xFFFD, O2 = 1.
  - BUTTERFLY_SATURATE_EN build: O1 = 0x7FFF, O2 = 1.
- Back-to-back in_valid with two data sets, then in_valid=0, then reset asserted mid-stream:
  - Results appear in consecutive cycles.
  - Outputs hold while in_valid=0, with out_valid=0.
  - Outputs clear on the edge after reset is asserted.
